rr_grant_arbiter8: RTL and testbench
====================================

Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Internally it keeps an encoded 3-bit winner index. The one-hot grant vector is produced by the team's 3-to-8 decoder, with enable driven by grant_valid.
- Each granted requester holds the resource until it drops its request or a hold-time limit expires.
- Sits in front of any shared datapath or bus that lab designs multiplex across 8 clients.

Parameters:
- HOLD_MAX, 4, maximum consecutive cycles one requester may hold a grant; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- grant  output  8  one-hot grant; all zero when grant_valid=0.
- grant_id  output  3  encoded index of the current grantee.
- grant_valid  output  1  high while a grant is held.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - outputs: grant=8'h00, grant_id=3'd0, grant_valid=0.
  - internal: state=IDLE, ptr=3'd0, hold_cnt=0.
- Reset during a grant drops that grant at the same edge. Reset overrides all other events.
- States: IDLE, GRANT.
- Winner selection:
  - Combinational pick = first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7 modulo 8 (wraps 7->0).
  - any_req = |req.
- IDLE:
  - If any_req at an edge: grant_id<=pick, grant_valid<=1, hold_cnt<=0, go to GRANT.
  - Else stay in IDLE.
  - Latency: a request sampled at edge N gives a grant visible immediately after edge N (one registered stage).
- GRANT, end condition:
  - release = (req[grant_id]==0).
  - expire = (hold_cnt==HOLD_MAX-1).
  - end = release | expire.
- GRANT, not end: hold_cnt<=hold_cnt+1; grant unchanged.
- GRANT, end:
  - ptr<=grant_id+1 (mod 8).
  - The next winner is picked from the current req, scanning from grant_id+1. Back-to-back hand-over with no bubble cycle.
  - If any_req: grant_id<=that pick, hold_cnt<=0, stay in GRANT.
  - Else: grant_valid<=0, go to IDLE. grant_id keeps its last value.
  - An expired requester that still requests is lowest priority. If it is the only requester it is re-granted at once, so grant stays continuous and hold_cnt restarts at 0.
- Simultaneous release and expire are treated as a single end event.
- A requester raising req during another's grant waits; its req is not latched. Dropping req before being granted cancels the request.
- grant = decoder(grant_id) gated by grant_valid. Exactly one bit is set when grant_valid=1, none otherwise.
- Fairness: with all 8 requesting continuously, each is served once per 8 grants.

Decomposition:
- Shared package / header holds:
  - state encoding: IDLE=1'b0, GRANT=1'b1;
  - N_REQ=8;
  - IDX_W=3.
- Sub-module: instantiate the existing three_to_eight_decoder (out, enable, in) for grant, with enable=grant_valid and in=grant_id.
- Rotating priority pick stays in this block as a function or always block.

Test Plan:
- Reset idle: assert reset 2 cycles with req=8'hFF, release reset with req=8'h00 -> grant=8'h00, grant_valid=0, grant_id=0 throughout.
- Hand-over from reset: req=8'b0010_0100, ptr=0 -> after first edge grant_id=2, grant=8'h04. Clear req[2] -> after next edge grant_id=5, grant=8'h20, no idle cycle.
- Hold limit (HOLD_MAX=4): req=8'b0000_1001 held constant:
  - grant_id=0 for 4 cycles, then 3 for 4 cycles, then 0 for 4 cycles;
  - grant_valid never drops.
- Single requester and idle return (HOLD_MAX=4): req=8'h08 held -> grant=8'h08 continuously, hold_cnt cycling 0..3. Drop req -> next edge grant_valid=0, state IDLE.
- Wrap-around:
  - grant requester 6 via req=8'h40, then drop it so ptr=7;
  - then req=8'b1000_0001 -> grant_id=7 first;
  - after its release, grant_id=0.
- Reset mid-grant and full rotation:
  - while grant_id=5, assert reset -> next edge grant=0, ptr=0;
  - then, with HOLD_MAX=1 and req=8'hFF, grant_id sequence is 0,1,2,...,7,0 on consecutive cycles.

Source files
------------

// File: rtl/rr_grant_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin grant arbiter.
// Holds the FSM state encoding, requester count and index width, and the
// rotating-priority pick helper used by the arbiter core.
package rr_grant_arbiter8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // First set bit of req scanning start, start+1, ... modulo N_REQ.
    // The index add wraps naturally in IDX_W bits. Returns 0 if req is empty.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] start
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = start + IDX_W'(k);
            if (req[idx] && !found) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter8_decoder.sv
// 3-to-8 one-hot decoder with enable.
// Ports: out   - one-hot output, all zero when enable is low
//        enable - output enable
//        in    - encoded index
module three_to_eight_decoder
    import rr_grant_arbiter8_pkg::*;
(
    output logic [N_REQ-1:0] out,
    input  logic             enable,
    input  logic [IDX_W-1:0] in
);

    always_comb begin
        out = '0;
        if (enable) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// A grantee keeps the resource until it drops its request or has held it
// for HOLD_MAX cycles; the next winner is then picked in the same cycle,
// so hand-over has no bubble.
// Ports: clk         - rising-edge clock
//        reset       - synchronous active-high reset
//        req         - request vector, bit i = requester i
//        grant       - one-hot grant, zero when grant_valid is low
//        grant_id    - encoded index of the current grantee
//        grant_valid - high while a grant is held
module rr_grant_arbiter8
    import rr_grant_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             grant_valid
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic             grant_valid_q, grant_valid_d;

    logic             any_req;
    logic             release_c;
    logic             expire_c;
    logic [IDX_W-1:0] next_start;

    // Scanning from grant_id+1 makes the outgoing grantee lowest priority.
    assign next_start = grant_id_q + IDX_W'(1);
    assign any_req    = |req;
    assign release_c  = ~req[grant_id_q];
    assign expire_c   = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d    = rr_pick(req, ptr_q);
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (release_c || expire_c) begin
                    ptr_d = next_start;
                    if (any_req) begin
                        grant_id_d = rr_pick(req, next_start);
                        hold_cnt_d = '0;
                    end else begin
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

    three_to_eight_decoder u_dec (
        .out    (grant),
        .enable (grant_valid_q),
        .in     (grant_id_q)
    );

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed bench for rr_grant_arbiter8: one instance with HOLD_MAX=4 and
// one with HOLD_MAX=1, sharing clock, reset and request stimulus.
module tb_rr_grant_arbiter8;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic [7:0] grant1;
    logic [2:0] grant_id1;
    logic       grant_valid1;

    int total;
    int bad;

    rr_grant_arbiter8 #(.HOLD_MAX(4), .CNT_W(8)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    rr_grant_arbiter8 #(.HOLD_MAX(1), .CNT_W(8)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant1),
        .grant_id    (grant_id1),
        .grant_valid (grant_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 3'd0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: got grant=%h valid=%b id=%0d, want 00/0/0",
                         i, grant, grant_valid, grant_id);
            end
        end
        reset = 1'b0;
        req   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 3'd0) begin
                bad++;
                $display("FAIL reset_idle cyc%0d: got grant=%h valid=%b id=%0d, want 00/0/0",
                         i, grant, grant_valid, grant_id);
            end
        end
    endtask

    // ptr=0 after reset; ends with ptr=6.
    task automatic test_handover();
        req = 8'b0010_0100;
        step();
        total++;
        if (grant_id !== 3'd2 || grant !== 8'h04 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL handover_first: got id=%0d grant=%h valid=%b, want 2/04/1",
                     grant_id, grant, grant_valid);
        end
        req = 8'b0010_0000;
        step();
        total++;
        if (grant_id !== 3'd5 || grant !== 8'h20 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL handover_next: got id=%0d grant=%h valid=%b, want 5/20/1",
                     grant_id, grant, grant_valid);
        end
        req = 8'h00;
        step();
        total++;
        if (grant_valid !== 1'b0 || grant !== 8'h00 || grant_id !== 3'd5) begin
            bad++;
            $display("FAIL handover_idle: got id=%0d grant=%h valid=%b, want 5/00/0",
                     grant_id, grant, grant_valid);
        end
    endtask

    // ptr=6 on entry: scan 6,7,0 picks 0 first; ends with ptr=1.
    task automatic test_hold_limit();
        logic [2:0] exp_id [12];
        logic [7:0] exp_gnt;
        exp_id = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3,
                   3'd0, 3'd0, 3'd0, 3'd0};
        req = 8'b0000_1001;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_gnt = (exp_id[i] == 3'd0) ? 8'h01 : 8'h08;
            total++;
            if (grant_id !== exp_id[i] || grant !== exp_gnt || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_limit cyc%0d: got id=%0d grant=%h valid=%b, want %0d/%h/1",
                         i, grant_id, grant, grant_valid, exp_id[i], exp_gnt);
            end
        end
        req = 8'h00;
        step();
        total++;
        if (grant_valid !== 1'b0 || grant !== 8'h00) begin
            bad++;
            $display("FAIL hold_limit_idle: got grant=%h valid=%b, want 00/0", grant, grant_valid);
        end
    endtask

    // Lone requester is re-granted on expiry with no gap.
    task automatic test_single();
        req = 8'h08;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (grant !== 8'h08 || grant_id !== 3'd3 || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL single cyc%0d: got id=%0d grant=%h valid=%b, want 3/08/1",
                         i, grant_id, grant, grant_valid);
            end
        end
        req = 8'h00;
        step();
        total++;
        if (grant_valid !== 1'b0 || grant !== 8'h00 || grant_id !== 3'd3) begin
            bad++;
            $display("FAIL single_idle: got id=%0d grant=%h valid=%b, want 3/00/0",
                     grant_id, grant, grant_valid);
        end
    endtask

    task automatic test_wrap();
        req = 8'h40;
        step();
        total++;
        if (grant_id !== 3'd6 || grant !== 8'h40) begin
            bad++;
            $display("FAIL wrap_six: got id=%0d grant=%h, want 6/40", grant_id, grant);
        end
        req = 8'h00;
        step();
        req = 8'b1000_0001;
        step();
        total++;
        if (grant_id !== 3'd7 || grant !== 8'h80 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_seven: got id=%0d grant=%h valid=%b, want 7/80/1",
                     grant_id, grant, grant_valid);
        end
        req = 8'b0000_0001;
        step();
        total++;
        if (grant_id !== 3'd0 || grant !== 8'h01 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_zero: got id=%0d grant=%h valid=%b, want 0/01/1",
                     grant_id, grant, grant_valid);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid_rotation();
        logic [2:0] exp_main [5];
        logic [2:0] exp1;
        exp_main = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        // ptr=1 on entry; lone requester 5 is picked.
        req = 8'h20;
        step();
        total++;
        if (grant_id !== 3'd5 || grant !== 8'h20) begin
            bad++;
            $display("FAIL mid_setup: got id=%0d grant=%h, want 5/20", grant_id, grant);
        end
        reset = 1'b1;
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: got grant=%h valid=%b id=%0d, want 00/0/0",
                     grant, grant_valid, grant_id);
        end
        reset = 1'b0;
        req   = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            exp1 = 3'(i % 8);
            total++;
            if (grant_id1 !== exp1 || grant1 !== (8'h01 << exp1) || grant_valid1 !== 1'b1) begin
                bad++;
                $display("FAIL rotation cyc%0d: got id=%0d grant=%h valid=%b, want %0d/%h/1",
                         i, grant_id1, grant1, grant_valid1, exp1, 8'h01 << exp1);
            end
            if (i < 5) begin
                total++;
                if (grant_id !== exp_main[i] || grant_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rotation_hold4 cyc%0d: got id=%0d valid=%b, want %0d/1",
                             i, grant_id, grant_valid, exp_main[i]);
                end
            end
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = 8'h00;
        test_reset();
        test_handover();
        test_hold_limit();
        test_single();
        test_wrap();
        test_reset_mid_rotation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
